// File: rtl/fault_ram_pkg.sv
// Shared definitions for the fault-injecting RAM responder: default
// geometry, fault-mode encodings and the controller state encoding.
package fault_ram_pkg;

    localparam int DEF_DEPTH = 256;
    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] FM_NONE = 2'b00;
    localparam logic [1:0] FM_SA0  = 2'b01;
    localparam logic [1:0] FM_SA1  = 2'b10;
    localparam logic [1:0] FM_CPL  = 2'b11;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage : fault_ram_pkg

// File: rtl/fault_ram_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count accepted events, clear on reset, hold once saturated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/fault_ram.sv
// Single-port synchronous RAM responder for the March tester, with
// stuck-at and coupling fault injection, a power-up zero-fill sweep and
// saturating read/write access counters.
module fault_ram
    import fault_ram_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic                       wren,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH-1:0]           q,
    output logic                       ready,
    input  logic [1:0]                 fault_mode,
    input  logic [$clog2(DEPTH)-1:0]   fault_addr,
    input  logic [$clog2(WIDTH)-1:0]   fault_bit,
    input  logic [$clog2(DEPTH)-1:0]   aggr_addr,
    output logic [15:0]                rd_count,
    output logic [15:0]                wr_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Force the victim bit when the access hits the victim cell in a
    // stuck-at mode; every other combination passes the word through.
    function automatic logic [WIDTH-1:0] apply_stuck(
        input logic [WIDTH-1:0] value,
        input logic [1:0]       mode,
        input logic             hit,
        input logic [BW-1:0]    bit_idx
    );
        logic [WIDTH-1:0] res;
        res = value;
        if (hit) begin
            case (mode)
                FM_SA0:  res[bit_idx] = 1'b0;
                FM_SA1:  res[bit_idx] = 1'b1;
                default: res = value;
            endcase
        end else begin
            res = value;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    state_e           state_r;
    state_e           state_next_s;
    logic [AW-1:0]    init_ptr_r;
    logic             ready_r;
    logic [WIDTH-1:0] q_r;

    logic             acc_ok_s;
    logic             wr_go_s;
    logic             rd_go_s;
    logic             hit_s;
    logic [WIDTH-1:0] old_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] rdata_s;
    logic             cpl_flip_s;

    // Access qualification, fault masking and coupling trigger decode.
    always_comb begin
        acc_ok_s   = 1'b0;
        wr_go_s    = 1'b0;
        rd_go_s    = 1'b0;
        cpl_flip_s = 1'b0;
        hit_s      = (addr == fault_addr);
        old_s      = mem[addr];
        wdata_s    = apply_stuck(data, fault_mode, hit_s, fault_bit);
        rdata_s    = apply_stuck(old_s, fault_mode, hit_s, fault_bit);
        if (reset && (state_r == READY)) begin
            acc_ok_s = 1'b1;
            wr_go_s  = wren;
            rd_go_s  = ~wren;
        end else begin
            acc_ok_s = 1'b0;
        end
        // A self-coupled cell would fight its own write, so it is excluded.
        if (wr_go_s && (fault_mode == FM_CPL) && (addr == aggr_addr) &&
            (aggr_addr != fault_addr) && (wdata_s[fault_bit] != old_s[fault_bit])) begin
            cpl_flip_s = 1'b1;
        end else begin
            cpl_flip_s = 1'b0;
        end
    end

    // Next-state decode: the sweep leaves INIT on the clock writing the last word.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            INIT: begin
                if (init_ptr_r == LAST_ADDR) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = INIT;
                end
            end
            READY:   state_next_s = READY;
            default: state_next_s = INIT;
        endcase
    end

    // Controller registers: state, sweep pointer, ready flag and read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= INIT;
            init_ptr_r <= {AW{1'b0}};
            ready_r    <= 1'b0;
            q_r        <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == READY);
            if (state_r == INIT) begin
                init_ptr_r <= init_ptr_r + AW'(1);
            end else begin
                init_ptr_r <= init_ptr_r;
            end
            if (rd_go_s) begin
                q_r <= rdata_s;
            end else begin
                q_r <= q_r;
            end
        end
    end

    // Array update: zero-fill during the sweep, masked writes plus coupling
    // flips once ready. Reset itself leaves the contents alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_r == INIT) begin
                mem[init_ptr_r] <= {WIDTH{1'b0}};
            end else if (wr_go_s) begin
                mem[addr] <= wdata_s;
                if (cpl_flip_s) begin
                    mem[fault_addr][fault_bit] <= ~mem[fault_addr][fault_bit];
                end
            end
        end
    end

    sat_counter #(.W(16)) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_go_s),
        .count (rd_count)
    );

    sat_counter #(.W(16)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_go_s),
        .count (wr_count)
    );

    assign q     = q_r;
    assign ready = ready_r;

endmodule : fault_ram
